// File: rtl/sad_job_sched_pkg.sv
// Shared definitions for the SAD job scheduler: FSM encoding, default widths
// and the "no result yet" SAD value.
package sad_pkg;

    localparam int RES_W_DEF = 32;
    localparam int IDX_W_DEF = 7;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    // Wide enough for any RES_W up to 64; users slice the low RES_W bits.
    localparam logic [63:0] SAD_MAX = '1;

endpackage

// File: rtl/sad_job_sched_if.sv
// Scheduler <-> SAD engine link. The master (scheduler) pulses Eng_Go; the
// slave (engine) returns strobes only.
interface sad_job_sched_if #(
    parameter int RES_W = sad_pkg::RES_W_DEF
);
    // Strobe semantics, no backpressure: Eng_Go is a one-cycle start pulse;
    // Eng_Res is meaningful only in a cycle where Eng_Res_Valid is high, and
    // each such cycle delivers exactly one result; Eng_Done is a one-cycle
    // end-of-run pulse that may coincide with the final Eng_Res_Valid.
    logic             Eng_Go;
    logic             Eng_Res_Valid;
    logic [RES_W-1:0] Eng_Res;
    logic             Eng_Done;

    modport master (output Eng_Go, input Eng_Res_Valid, Eng_Res, Eng_Done);
    modport slave  (input Eng_Go, output Eng_Res_Valid, Eng_Res, Eng_Done);

endinterface

// File: rtl/sad_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sad_job_sched.sv
// Round-robin scheduler sharing one SAD engine: grants a requester, starts the
// engine, tracks the minimum SAD and its block index, and acks the requester.
module sad_job_sched
    import sad_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int RES_W  = RES_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int WDOG_W = 20
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   Req,
    output logic [NREQ-1:0]   Gnt,
    output logic [NREQ-1:0]   Ack,
    output logic [RES_W-1:0]  Best_Sad,
    output logic [IDX_W-1:0]  Best_Idx,
    output logic [IDX_W:0]    Res_Cnt,
    output logic              Err,
    output logic              Busy,
    sad_job_sched_if.master   eng
);

    localparam int PW = $clog2(NREQ);
    localparam logic [IDX_W:0]    CNT_FULL = {1'b1, {IDX_W{1'b0}}};
    localparam logic [WDOG_W-1:0] WDOG_PRE = {{(WDOG_W-1){1'b1}}, 1'b0};
    localparam logic [RES_W-1:0]  SAD_INIT = SAD_MAX[RES_W-1:0];

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d, win_q, win_d, win_sel;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d, arb_gnt;
    logic [RES_W-1:0]  best_sad_q, best_sad_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [IDX_W:0]    res_cnt_q, res_cnt_d;
    logic              err_q, err_d, busy_q, busy_d, eng_go_q, eng_go_d;
    logic              arb_any;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (Req),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    always_comb begin
        win_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) win_sel = PW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        wdog_d     = wdog_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        res_cnt_d  = res_cnt_q;
        err_d      = err_q;
        eng_go_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d    = S_GRANT;
                    gnt_d      = arb_gnt;
                    win_d      = win_sel;
                    eng_go_d   = 1'b1;
                    best_sad_d = SAD_INIT;
                    best_idx_d = '0;
                    res_cnt_d  = '0;
                    err_d      = 1'b0;
                    wdog_d     = '0;
                end
            end
            S_GRANT: state_d = S_RUN;
            S_RUN: begin
                wdog_d = wdog_q + 1'b1;
                // A result arriving with the count already full is dropped and flagged.
                if (eng.Eng_Res_Valid) begin
                    if (res_cnt_q == CNT_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        if (eng.Eng_Res < best_sad_q) begin
                            best_sad_d = eng.Eng_Res;
                            best_idx_d = res_cnt_q[IDX_W-1:0];
                        end
                        res_cnt_d = res_cnt_q + 1'b1;
                    end
                end
                if (wdog_q == WDOG_PRE) err_d = 1'b1;
                if (eng.Eng_Done || wdog_q == WDOG_PRE) begin
                    state_d = S_REPORT;
                    ack_d   = gnt_q;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                rr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            win_q      <= '0;
            wdog_q     <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            best_sad_q <= SAD_INIT;
            best_idx_q <= '0;
            res_cnt_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            eng_go_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            win_q      <= win_d;
            wdog_q     <= wdog_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
            res_cnt_q  <= res_cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            eng_go_q   <= eng_go_d;
        end
    end

    assign Gnt        = gnt_q;
    assign Ack        = ack_q;
    assign Best_Sad   = best_sad_q;
    assign Best_Idx   = best_idx_q;
    assign Res_Cnt    = res_cnt_q;
    assign Err        = err_q;
    assign Busy       = busy_q;
    assign eng.Eng_Go = eng_go_q;

endmodule

// File: tb/tb_sad_job_sched.sv
// Bench for sad_job_sched: a default-size instance plus a small one (IDX_W=2,
// WDOG_W=4) fed the same stimulus for the overflow and watchdog corners.
module tb_sad_job_sched;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [3:0]  Req = '0;

  logic [3:0]  gnt_a, ack_a, gnt_b, ack_b;
  logic [31:0] best_a, best_b;
  logic [6:0]  idx_a;
  logic [1:0]  idx_b;
  logic [7:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic        err_a, err_b, busy_a, busy_b;

  sad_job_sched_if #(.RES_W(32)) ifa ();
  sad_job_sched_if #(.RES_W(32)) ifb ();

  assign ifb.Eng_Res_Valid = ifa.Eng_Res_Valid;
  assign ifb.Eng_Res       = ifa.Eng_Res;
  assign ifb.Eng_Done      = ifa.Eng_Done;

  sad_job_sched #(.NREQ(4), .RES_W(32), .IDX_W(7), .WDOG_W(20)) dut_a (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Gnt(gnt_a), .Ack(ack_a),
    .Best_Sad(best_a), .Best_Idx(idx_a), .Res_Cnt(cnt_a), .Err(err_a),
    .Busy(busy_a), .eng(ifa)
  );

  sad_job_sched #(.NREQ(4), .RES_W(32), .IDX_W(2), .WDOG_W(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Gnt(gnt_b), .Ack(ack_b),
    .Best_Sad(best_b), .Best_Idx(idx_b), .Res_Cnt(cnt_b), .Err(err_b),
    .Busy(busy_b), .eng(ifb)
  );

  // clock / global time limit
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] res_q[$];
  int          model_ptr = 0;

  logic [3:0]  g_gnt, g_ack0, g_ack, g_gnt_rep, g_ack_after, g_gnt_after;
  logic        g_go, g_go2, g_busy, g_err, g_busy_after;
  logic [31:0] g_best, g_best_after, gb_best;
  logic [6:0]  g_idx;
  logic [7:0]  g_cnt;
  logic [2:0]  gb_cnt;
  logic [1:0]  gb_idx;
  logic        gb_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: first set request at or after the pointer, wrapping; pointer moves past winner.
  function automatic logic [3:0] model_grant(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      int k = (model_ptr + i) % 4;
      if (r[k]) begin
        model_ptr = (k + 1) % 4;
        return 4'b0001 << k;
      end
    end
    return 4'b0000;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; Req = '0;
    ifa.Eng_Res_Valid = 1'b0; ifa.Eng_Done = 1'b0; ifa.Eng_Res = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    model_ptr = 0;
  endtask

  // One job on the shared stimulus; stray Valid/Done during GRANT must be ignored.
  task automatic run_job(input logic [3:0] req, input bit dwl, input bit gaps, input bit drop);
    @(negedge Clk);
    Req = req;
    @(posedge Clk); #1;
    g_gnt = gnt_a; g_go = ifa.Eng_Go; g_busy = busy_a; g_ack0 = ack_a;
    @(negedge Clk);
    if (drop) Req = '0;
    ifa.Eng_Res_Valid = 1'b1; ifa.Eng_Res = '0; ifa.Eng_Done = 1'b1;
    @(posedge Clk); #1;
    g_go2 = ifa.Eng_Go;
    foreach (res_q[i]) begin
      @(negedge Clk);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ifa.Eng_Res_Valid = 1'b0; ifa.Eng_Done = 1'b0;
          @(negedge Clk);
        end
      end
      ifa.Eng_Res_Valid = 1'b1;
      ifa.Eng_Res       = res_q[i];
      ifa.Eng_Done      = dwl && (i == res_q.size() - 1);
    end
    if (!dwl || res_q.size() == 0) begin
      @(negedge Clk);
      ifa.Eng_Res_Valid = 1'b0; ifa.Eng_Done = 1'b1;
    end
    @(posedge Clk); #1;
    g_ack = ack_a; g_gnt_rep = gnt_a; g_best = best_a; g_idx = idx_a;
    g_cnt = cnt_a; g_err = err_a;
    gb_best = best_b; gb_idx = idx_b; gb_cnt = cnt_b; gb_err = err_b;
    @(negedge Clk);
    ifa.Eng_Res_Valid = 1'b0; ifa.Eng_Done = 1'b0;
    @(posedge Clk); #1;
    g_ack_after = ack_a; g_gnt_after = gnt_a; g_busy_after = busy_a; g_best_after = best_a;
  endtask

  task automatic check_job(input string tag, input logic [3:0] eg, input logic [31:0] eb,
                           input int ei, input int ec, input bit ee);
    chk({tag, "_gnt"}, g_gnt, eg);
    chk({tag, "_go"}, g_go, 1);
    chk({tag, "_busy"}, g_busy, 1);
    chk({tag, "_ack_early"}, g_ack0, 0);
    chk({tag, "_go_drop"}, g_go2, 0);
    chk({tag, "_ack"}, g_ack, eg);
    chk({tag, "_gnt_report"}, g_gnt_rep, eg);
    chk({tag, "_best"}, g_best, eb);
    chk({tag, "_idx"}, g_idx, ei);
    chk({tag, "_cnt"}, g_cnt, ec);
    chk({tag, "_err"}, g_err, ee);
    chk({tag, "_ack_after"}, g_ack_after, 0);
    chk({tag, "_gnt_after"}, g_gnt_after, 0);
    chk({tag, "_busy_after"}, g_busy_after, 0);
    chk({tag, "_best_hold"}, g_best_after, eb);
  endtask

  typedef struct {
    logic [3:0]  req;
    int          n;
    logic [31:0] res[6];
    bit          dwl;
    logic [3:0]  gnt;
    logic [31:0] best;
    int          idx;
    int          cnt;
    bit          err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [3:0]  r, eg;
    logic [31:0] mbest;
    int          midx, mcnt, n, wd;
    bit          dwl;

    tbl[0] = '{4'b1111, 2, '{5, 3, 0, 0, 0, 0},     1'b0, 4'b0001, 32'd3,        1, 2, 1'b0};
    tbl[1] = '{4'b1111, 0, '{0, 0, 0, 0, 0, 0},     1'b0, 4'b0010, 32'hFFFF_FFFF, 0, 0, 1'b0};
    tbl[2] = '{4'b1111, 3, '{9, 8, 7, 0, 0, 0},     1'b1, 4'b0100, 32'd7,        2, 3, 1'b0};
    tbl[3] = '{4'b1111, 3, '{4, 4, 6, 0, 0, 0},     1'b0, 4'b1000, 32'd4,        0, 3, 1'b0};
    tbl[4] = '{4'b1111, 1, '{100, 0, 0, 0, 0, 0},   1'b1, 4'b0001, 32'd100,      0, 1, 1'b0};
    tbl[5] = '{4'b0001, 4, '{50, 20, 20, 35, 0, 0}, 1'b0, 4'b0001, 32'd20,       1, 4, 1'b0};
    tbl[6] = '{4'b0110, 2, '{1, 0, 0, 0, 0, 0},     1'b0, 4'b0010, 32'd0,        1, 2, 1'b0};

    ifa.Eng_Res_Valid = 1'b0; ifa.Eng_Done = 1'b0; ifa.Eng_Res = '0;
    do_reset();
    #1;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_best", best_a, 32'hFFFF_FFFF);
    chk("rst_idx", idx_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_go", ifa.Eng_Go, 0);

    // table vectors; vector 4 also drops its request right after the grant
    for (int i = 0; i < 7; i++) begin
      res_q.delete();
      for (int j = 0; j < tbl[i].n; j++) res_q.push_back(tbl[i].res[j]);
      eg = model_grant(tbl[i].req);
      run_job(tbl[i].req, tbl[i].dwl, 1'b0, i == 4);
      check_job($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].best, tbl[i].idx, tbl[i].cnt, tbl[i].err);
    end

    // reset in the middle of RUN after two accepted results
    @(negedge Clk); Req = 4'b0001;
    @(posedge Clk);
    @(negedge Clk); Req = '0;
    @(posedge Clk);
    @(negedge Clk); ifa.Eng_Res_Valid = 1'b1; ifa.Eng_Res = 32'd3;
    @(negedge Clk); ifa.Eng_Res = 32'd2;
    @(negedge Clk); ifa.Eng_Res_Valid = 1'b0; Rst = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_gnt", gnt_a, 0);
    chk("midrst_best", best_a, 32'hFFFF_FFFF);
    chk("midrst_cnt", cnt_a, 0);
    chk("midrst_go", ifa.Eng_Go, 0);
    @(negedge Clk); Rst = 1'b0; model_ptr = 0;
    res_q.delete();
    eg = model_grant(4'b1010);
    run_job(4'b1010, 1'b0, 1'b0, 1'b0);
    check_job("midrst_job", 4'b0010, 32'hFFFF_FFFF, 0, 0, 1'b0);

    // randomized jobs against the reference model
    for (int j = 0; j < 30; j++) begin
      r   = 4'($urandom_range(1, 15));
      n   = $urandom_range(0, 6);
      dwl = (n > 0) && ($urandom_range(0, 1) == 1);
      res_q.delete();
      mbest = 32'hFFFF_FFFF; midx = 0; mcnt = 0;
      for (int k = 0; k < n; k++) begin
        res_q.push_back(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20)));
        if (res_q[k] < mbest) begin
          mbest = res_q[k];
          midx  = k;
        end
        mcnt++;
      end
      exp_q.push_back(model_grant(r));
      run_job(r, dwl, 1'b1, $urandom_range(0, 1) == 1);
      check_job($sformatf("rnd%0d", j), exp_q.pop_front(), mbest, midx, mcnt, 1'b0);
    end

    // watchdog on the small instance: no Done, REPORT after 15 RUN cycles
    do_reset();
    Req = 4'b0001;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    wd = 0;
    while (wd < 40 && ack_b == 4'b0000) begin
      @(posedge Clk); #1;
      wd++;
    end
    chk("wdog_cycles", wd, 15);
    chk("wdog_ack", ack_b, 4'b0001);
    chk("wdog_err", err_b, 1);
    chk("wdog_cnt", cnt_b, 0);
    chk("wdog_best", best_b, 32'hFFFF_FFFF);

    // overflow on the small instance: fifth result is dropped and flagged
    do_reset();
    res_q.delete();
    res_q.push_back(32'd5); res_q.push_back(32'd6); res_q.push_back(32'd7);
    res_q.push_back(32'd8); res_q.push_back(32'd1);
    eg = model_grant(4'b0001);
    run_job(4'b0001, 1'b0, 1'b0, 1'b0);
    check_job("ovf_a", 4'b0001, 32'd1, 4, 5, 1'b0);
    chk("ovf_b_cnt", gb_cnt, 4);
    chk("ovf_b_err", gb_err, 1);
    chk("ovf_b_best", gb_best, 5);
    chk("ovf_b_idx", gb_idx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
